mem_data_arbiter: RTL and testbench
===================================

MEM_DATA_ARBITER -- requirements
Module: mem_data_arbiter

Interface
REQ-001 Parameter LOCK_MAX, default 8: maximum consecutive grants to port B while B_LOCK is held.
REQ-002 MEM_CLK  in  1: single clock; all state updates on rising edge.
REQ-003 MEM_RST_N  in  1: reset, synchronous, active-low.
REQ-004 A_REQ, A_WE  in  1 each: CPU data-port request and write-enable.
REQ-005 A_ADDR, A_DIN  in  32 each: CPU byte address and store data.
REQ-006 A_SIZE  in  2 / A_SIGN  in  1: CPU access size (0 byte, 1 half, 2 word) and load sign (1 = unsigned).
REQ-007 A_GNT, A_RVALID, A_ERR  out  1 each: CPU grant, read-data valid and misalignment error.
REQ-008 A_RDATA  out  32: CPU load data.
REQ-009 B_REQ, B_WE, B_LOCK  in  1 each / B_ADDR, B_DIN  in  32 each / B_SIZE  in  2 / B_SIGN  in  1: DMA/debug port, with the same meanings as the A_* inputs; B_LOCK requests burst ownership.
REQ-010 B_GNT, B_RVALID, B_ERR  out  1 each / B_RDATA  out  32: DMA/debug port outputs, with the same meanings as the A_* outputs.
REQ-011 MEM_ADDR2, MEM_DIN2  out  32 each / MEM_SIZE  out  2 / MEM_SIGN, MEM_READ2, MEM_WRITE2  out  1 each: drive the shared memory data port.
REQ-012 MEM_DOUT2  in  32: sliced load data from memory, valid the cycle after MEM_READ2.

Function
REQ-013 Request handshake: a requester holds REQ and all request fields stable until it samples GNT=1 at a rising edge; the transfer completes in that cycle.
REQ-014 GNT is combinational from the current REQs and arbiter state; at most one GNT is high per cycle.
REQ-015 Arbitration: one requester -> that requester wins; both requesting -> round-robin against a last_winner register, i.e. the port that did not win last.
REQ-016 last_winner updates to the granted port on every grant edge and resets to B, so A wins the first contended cycle after reset.
REQ-017 Lock: while B owns the port, B_LOCK=1 and lock_cnt<LOCK_MAX, B wins even when A requests; lock_cnt increments on each such B grant.
REQ-018 Lock release: when lock_cnt reaches LOCK_MAX, A wins the next contended cycle; lock_cnt clears on any A grant, and on any cycle with B_LOCK=0.
REQ-019 Misalignment check: word with ADDR[1:0]!=0, or half with ADDR[0]=1, is misaligned.
REQ-020 Misaligned request: GNT=1 and ERR=1 in the same cycle; MEM_READ2=MEM_WRITE2=0; no RVALID follows.
REQ-021 Aligned granted request: MEM_* outputs mux the winner's fields; MEM_WRITE2=WE; MEM_READ2=!WE.
REQ-022 No grant: MEM_READ2=MEM_WRITE2=0 and MEM_ADDR2=MEM_DIN2=0; MEM_SIZE=2; MEM_SIGN=0.
REQ-023 Read latency: a registered rsp_owner/rsp_valid pair records every aligned read grant.
REQ-024 The owner's RVALID is high exactly one cycle after the read grant, with RDATA=MEM_DOUT2 combinationally in that cycle.
REQ-025 Non-owner RDATA is 0.
REQ-026 Back-to-back: a new grant is allowed in the RVALID cycle of the previous read; reads to both ports on consecutive cycles return in grant order.
REQ-027 Writes produce no RVALID; a write followed next cycle by a read of the same address returns the new data.

Reset
REQ-028 While MEM_RST_N=0 at an edge: last_winner=B, lock_cnt=0, rsp_valid=0, rsp_owner=A.
REQ-029 During that reset cycle all GNT, RVALID, ERR, MEM_READ2 and MEM_WRITE2 outputs are 0 and RDATA=0.
REQ-030 Reset asserted the cycle after a read grant suppresses that read's RVALID.

Verification
REQ-031 After reset, A_REQ=B_REQ=1 (both reads), held for 4 cycles -> grant order A,B,A,B; each RVALID one cycle after its grant, routed to the correct port.
REQ-032 A writes 0xDEADBEEF to 0x100 (size 2), next cycle A reads 0x100 -> A_RVALID with A_RDATA=0xDEADBEEF two cycles after the write grant.
REQ-033 B_LOCK=1, B_REQ=1 continuously, A_REQ=1, LOCK_MAX=8 -> 8 consecutive B_GNT, then A_GNT, then B resumes.
REQ-034 A word read at 0x102 -> A_GNT=A_ERR=1 same cycle, MEM_READ2=0, no A_RVALID; same for a half read at 0x101.
REQ-035 Read granted to B, then MEM_RST_N=0 next cycle -> B_RVALID stays 0; after release, first contended cycle grants A.
REQ-036 Single requester B byte write 0xAB to 0x203 with no A traffic -> B_GNT same cycle, MEM_WRITE2=1, MEM_SIZE=0, MEM_ADDR2=0x203.

Source files
------------

// File: rtl/mem_data_arbiter.sv
// Two-port arbiter for the shared memory data port: CPU port A and DMA/debug port B,
// with round-robin fairness, a bounded B burst lock, misalignment rejection and read-return routing.
module mem_data_arbiter #(
   parameter int unsigned LOCK_MAX = 8
) (
   input  logic        mem_clk_i,
   input  logic        mem_rst_n_i,
   // CPU data port
   input  logic        a_req_i,
   input  logic        a_we_i,
   input  logic [31:0] a_addr_i,
   input  logic [31:0] a_din_i,
   input  logic [1:0]  a_size_i,
   input  logic        a_sign_i,
   output logic        a_gnt_o,
   output logic        a_rvalid_o,
   output logic        a_err_o,
   output logic [31:0] a_rdata_o,
   // DMA/debug port
   input  logic        b_req_i,
   input  logic        b_we_i,
   input  logic        b_lock_i,
   input  logic [31:0] b_addr_i,
   input  logic [31:0] b_din_i,
   input  logic [1:0]  b_size_i,
   input  logic        b_sign_i,
   output logic        b_gnt_o,
   output logic        b_rvalid_o,
   output logic        b_err_o,
   output logic [31:0] b_rdata_o,
   // shared memory data port
   output logic [31:0] mem_addr2_o,
   output logic [31:0] mem_din2_o,
   output logic [1:0]  mem_size_o,
   output logic        mem_sign_o,
   output logic        mem_read2_o,
   output logic        mem_write2_o,
   input  logic [31:0] mem_dout2_i
);

   localparam int unsigned CNT_W = ($clog2(LOCK_MAX + 1) < 1) ? 1 : $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_MAX);

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   port_e            last_winner_q, last_winner_d;
   port_e            rsp_owner_q, rsp_owner_d;
   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic             rsp_valid_q, rsp_valid_d;

   logic             gnt_a_s, gnt_b_s, any_gnt_s, lock_hold_s, xfer_ok_s, sel_mis_s;
   port_e            winner_s;
   logic             sel_we_s, sel_sign_s;
   logic [31:0]      sel_addr_s, sel_din_s;
   logic [1:0]       sel_size_s;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      case (size)
         2'd1:    mis = addr_lo[0];
         2'd2:    mis = (addr_lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Arbitration: B keeps the port while it holds the lock and the burst budget remains
   always_comb begin
      gnt_a_s     = 1'b0;
      gnt_b_s     = 1'b0;
      lock_hold_s = b_lock_i && (last_winner_q == PORT_B) && (lock_cnt_q < LOCK_LIM);
      if (!mem_rst_n_i) begin
         gnt_a_s = 1'b0;
         gnt_b_s = 1'b0;
      end else if (a_req_i && b_req_i) begin
         if (lock_hold_s || (last_winner_q == PORT_A)) begin
            gnt_b_s = 1'b1;
         end else begin
            gnt_a_s = 1'b1;
         end
      end else if (a_req_i) begin
         gnt_a_s = 1'b1;
      end else if (b_req_i) begin
         gnt_b_s = 1'b1;
      end else begin
         gnt_a_s = 1'b0;
         gnt_b_s = 1'b0;
      end
   end

   assign any_gnt_s  = gnt_a_s || gnt_b_s;
   assign winner_s   = gnt_b_s ? PORT_B : PORT_A;
   assign sel_we_s   = gnt_b_s ? b_we_i   : a_we_i;
   assign sel_addr_s = gnt_b_s ? b_addr_i : a_addr_i;
   assign sel_din_s  = gnt_b_s ? b_din_i  : a_din_i;
   assign sel_size_s = gnt_b_s ? b_size_i : a_size_i;
   assign sel_sign_s = gnt_b_s ? b_sign_i : a_sign_i;
   assign sel_mis_s  = is_misaligned(sel_size_s, sel_addr_s[1:0]);
   assign xfer_ok_s  = any_gnt_s && !sel_mis_s;

   // Memory port drive; misaligned grants complete with an error and never touch memory
   always_comb begin
      mem_addr2_o  = 32'd0;
      mem_din2_o   = 32'd0;
      mem_size_o   = 2'd2;
      mem_sign_o   = 1'b0;
      mem_read2_o  = 1'b0;
      mem_write2_o = 1'b0;
      if (xfer_ok_s) begin
         mem_addr2_o  = sel_addr_s;
         mem_din2_o   = sel_din_s;
         mem_size_o   = sel_size_s;
         mem_sign_o   = sel_sign_s;
         mem_read2_o  = !sel_we_s;
         mem_write2_o = sel_we_s;
      end else begin
         mem_read2_o  = 1'b0;
         mem_write2_o = 1'b0;
      end
   end

   // Next-state for fairness, lock budget and the one-deep read return tracker
   always_comb begin
      last_winner_d = any_gnt_s ? winner_s : last_winner_q;
      lock_cnt_d    = lock_cnt_q;
      if (!b_lock_i || gnt_a_s) begin
         lock_cnt_d = '0;
      end else if (gnt_b_s && (lock_cnt_q < LOCK_LIM)) begin
         lock_cnt_d = lock_cnt_q + CNT_W'(1);
      end else begin
         lock_cnt_d = lock_cnt_q;
      end
      rsp_valid_d = xfer_ok_s && !sel_we_s;
      rsp_owner_d = rsp_valid_d ? winner_s : rsp_owner_q;
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge mem_clk_i) begin
      if (!mem_rst_n_i) begin
         last_winner_q <= PORT_B;
         lock_cnt_q    <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_owner_q   <= PORT_A;
      end else begin
         last_winner_q <= last_winner_d;
         lock_cnt_q    <= lock_cnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_owner_q   <= rsp_owner_d;
      end
   end

   // Reset gating here also drops a read return that reset lands on
   assign a_gnt_o    = gnt_a_s;
   assign b_gnt_o    = gnt_b_s;
   assign a_err_o    = gnt_a_s && sel_mis_s;
   assign b_err_o    = gnt_b_s && sel_mis_s;
   assign a_rvalid_o = mem_rst_n_i && rsp_valid_q && (rsp_owner_q == PORT_A);
   assign b_rvalid_o = mem_rst_n_i && rsp_valid_q && (rsp_owner_q == PORT_B);
   assign a_rdata_o  = a_rvalid_o ? mem_dout2_i : 32'd0;
   assign b_rdata_o  = b_rvalid_o ? mem_dout2_i : 32'd0;

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Directed bench for mem_data_arbiter with a small byte-addressed memory model behind the shared port.
module tb_mem_data_arbiter;

   logic        clk, rst_n;
   logic        a_req, a_we, a_sign, b_req, b_we, b_lock, b_sign;
   logic [31:0] a_addr, a_din, b_addr, b_din;
   logic [1:0]  a_size, b_size;
   logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
   logic [31:0] a_rdata, b_rdata;
   logic [31:0] mem_addr, mem_din, mem_dout;
   logic [1:0]  mem_size;
   logic        mem_sign, mem_read, mem_write;

   int n_vec = 0;
   int n_err = 0;

   mem_data_arbiter #(.LOCK_MAX(8)) dut (
      .mem_clk_i(clk), .mem_rst_n_i(rst_n),
      .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_din_i(a_din),
      .a_size_i(a_size), .a_sign_i(a_sign),
      .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_err_o(a_err), .a_rdata_o(a_rdata),
      .b_req_i(b_req), .b_we_i(b_we), .b_lock_i(b_lock), .b_addr_i(b_addr), .b_din_i(b_din),
      .b_size_i(b_size), .b_sign_i(b_sign),
      .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_err_o(b_err), .b_rdata_o(b_rdata),
      .mem_addr2_o(mem_addr), .mem_din2_o(mem_din), .mem_size_o(mem_size),
      .mem_sign_o(mem_sign), .mem_read2_o(mem_read), .mem_write2_o(mem_write),
      .mem_dout2_i(mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Unwritten bytes read back as the low byte of their own address
   bit         wr_v [0:1023];
   logic [7:0] wr_d [0:1023];

   function automatic logic [7:0] rd_byte(input logic [9:0] ad);
      return wr_v[ad] ? wr_d[ad] : ad[7:0];
   endfunction

   always @(posedge clk) begin
      logic [9:0] ad;
      logic [7:0] b0, b1, b2, b3;
      ad = mem_addr[9:0];
      b0 = rd_byte(ad);
      b1 = rd_byte(ad + 10'd1);
      b2 = rd_byte(ad + 10'd2);
      b3 = rd_byte(ad + 10'd3);
      if (mem_write) begin
         wr_v[ad] <= 1'b1; wr_d[ad] <= mem_din[7:0];
         if (mem_size != 2'd0) begin
            wr_v[ad + 10'd1] <= 1'b1; wr_d[ad + 10'd1] <= mem_din[15:8];
         end
         if (mem_size == 2'd2) begin
            wr_v[ad + 10'd2] <= 1'b1; wr_d[ad + 10'd2] <= mem_din[23:16];
            wr_v[ad + 10'd3] <= 1'b1; wr_d[ad + 10'd3] <= mem_din[31:24];
         end
      end
      if (mem_read) begin
         case (mem_size)
            2'd0:    mem_dout <= mem_sign ? {24'd0, b0} : {{24{b0[7]}}, b0};
            2'd1:    mem_dout <= mem_sign ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default: mem_dout <= {b3, b2, b1, b0};
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_a(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] din, input logic [1:0] size, input logic sign);
      a_req = req; a_we = we; a_addr = addr; a_din = din; a_size = size; a_sign = sign;
   endtask

   task automatic set_b(input logic req, input logic we, input logic lock, input logic [31:0] addr,
                        input logic [31:0] din, input logic [1:0] size, input logic sign);
      b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_din = din; b_size = size; b_sign = sign;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      mem_dout = 32'd0;
      rst_n = 1'b0;
      set_a(1'b1, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0);
      set_b(1'b1, 1'b0, 1'b0, 32'h20, 32'd0, 2'd2, 1'b0);
      tick(); tick();
      #2;
      chk("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
      chk("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
      chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
      chk("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
      chk("rst_rdata", a_rdata | b_rdata, 32'd0);
      tick();
      rst_n = 1'b1;

      // contended reads alternate A,B,A,B and return one cycle later
      for (int i = 0; i < 4; i++) begin
         #2;
         chk("rr_a_gnt", {31'd0, a_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_b_gnt", {31'd0, b_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
         chk("rr_addr", mem_addr, (i % 2 == 0) ? 32'h10 : 32'h20);
         chk("rr_a_rvalid", {31'd0, a_rvalid}, (i % 2 == 1) ? 32'd1 : 32'd0);
         chk("rr_b_rvalid", {31'd0, b_rvalid}, (i == 2) ? 32'd1 : 32'd0);
         if (i % 2 == 1) chk("rr_a_rdata", a_rdata, 32'h13121110);
         if (i == 2) chk("rr_b_rdata", b_rdata, 32'h23222120);
         tick();
      end
      set_a(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
      set_b(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
      #2;
      chk("idle_b_rvalid", {31'd0, b_rvalid}, 32'd1);
      chk("idle_b_rdata", b_rdata, 32'h23222120);
      chk("idle_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
      chk("idle_mem_ctl", {30'd0, mem_read, mem_write}, 32'd0);
      chk("idle_mem_addr", mem_addr, 32'd0);
      chk("idle_mem_size", {30'd0, mem_size}, 32'd2);
      tick();

      // write then read the same word
      set_a(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0);
      #2;
      chk("wr_a_gnt", {31'd0, a_gnt}, 32'd1);
      chk("wr_mem_ctl", {30'd0, mem_read, mem_write}, 32'd1);
      chk("wr_mem_din", mem_din, 32'hDEADBEEF);
      chk("wr_mem_addr", mem_addr, 32'h100);
      tick();
      set_a(1'b1, 1'b0, 32'h100, 32'd0, 2'd2, 1'b0);
      #2;
      chk("rd_mem_read", {31'd0, mem_read}, 32'd1);
      chk("wr_no_rvalid", {31'd0, a_rvalid}, 32'd0);
      tick();
      set_a(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
      #2;
      chk("raw_a_rvalid", {31'd0, a_rvalid}, 32'd1);
      chk("raw_a_rdata", a_rdata, 32'hDEADBEEF);
      tick();

      // misaligned word and half, then an aligned signed byte
      set_a(1'b1, 1'b0, 32'h102, 32'd0, 2'd2, 1'b0);
      #2;
      chk("misw_gnt_err", {30'd0, a_gnt, a_err}, 32'd3);
      chk("misw_mem_read", {31'd0, mem_read}, 32'd0);
      tick();
      set_a(1'b1, 1'b0, 32'h101, 32'd0, 2'd1, 1'b0);
      #2;
      chk("mish_gnt_err", {30'd0, a_gnt, a_err}, 32'd3);
      chk("mish_mem_read", {31'd0, mem_read}, 32'd0);
      chk("misw_no_rvalid", {31'd0, a_rvalid}, 32'd0);
      tick();
      set_a(1'b1, 1'b0, 32'hFF, 32'd0, 2'd0, 1'b0);
      #2;
      chk("byte_err", {31'd0, a_err}, 32'd0);
      chk("byte_mem_read", {31'd0, mem_read}, 32'd1);
      chk("byte_mem_size", {30'd0, mem_size}, 32'd0);
      chk("mish_no_rvalid", {31'd0, a_rvalid}, 32'd0);
      tick();
      set_a(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
      #2;
      chk("byte_rdata", a_rdata, 32'hFFFFFFFF);
      tick();

      // B alone: byte write then unsigned byte read
      set_b(1'b1, 1'b1, 1'b0, 32'h203, 32'hAB, 2'd0, 1'b0);
      #2;
      chk("bw_gnt", {30'd0, a_gnt, b_gnt}, 32'd1);
      chk("bw_mem_write", {31'd0, mem_write}, 32'd1);
      chk("bw_mem_size", {30'd0, mem_size}, 32'd0);
      chk("bw_mem_addr", mem_addr, 32'h203);
      chk("bw_mem_din", mem_din, 32'hAB);
      tick();
      set_b(1'b1, 1'b0, 1'b0, 32'h203, 32'd0, 2'd0, 1'b1);
      #2;
      chk("br_gnt", {31'd0, b_gnt}, 32'd1);
      tick();

      // locked burst: eight B grants, one A grant, then B again
      set_a(1'b1, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0);
      set_b(1'b1, 1'b0, 1'b1, 32'h20, 32'd0, 2'd2, 1'b0);
      #2;
      chk("br_rdata", b_rdata, 32'hAB);
      for (int k = 0; k < 10; k++) begin
         if (k != 0) #2;
         chk("lock_a_gnt", {31'd0, a_gnt}, (k == 8) ? 32'd1 : 32'd0);
         chk("lock_b_gnt", {31'd0, b_gnt}, (k == 8) ? 32'd0 : 32'd1);
         tick();
      end
      set_a(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
      set_b(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
      tick();

      // reset right after a B read grant swallows its return
      set_b(1'b1, 1'b0, 1'b0, 32'h20, 32'd0, 2'd2, 1'b0);
      #2;
      chk("pre_rst_b_gnt", {31'd0, b_gnt}, 32'd1);
      tick();
      rst_n = 1'b0;
      set_a(1'b1, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0);
      #2;
      chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
      chk("rst_b_rdata", b_rdata, 32'd0);
      chk("rst_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
      tick();
      rst_n = 1'b1;
      #2;
      chk("post_rst_gnt", {30'd0, a_gnt, b_gnt}, 32'd2);
      chk("post_rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
